// File: rtl/add_carry_seq.sv
// add_carry_seq: multi-cycle adder/subtractor, one CHUNK-bit slice per clock, LSB slice first.
// Define ADD_CARRY_SEQ_FLAGS_EN to add the ovf and zero result flags.
module add_carry_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef ADD_CARRY_SEQ_FLAGS_EN
    output logic             ovf,
    output logic             zero,
`endif
    output logic             cout
);
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state, state_next;
    logic [NSLICE-1:0][CHUNK-1:0] op_a, op_b, res, res_next;
    logic [CW-1:0]                cnt;
    logic                         carry, last;
    logic [CHUNK:0]               slice_sum;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign sum       = res;
    assign last      = cnt == CW'(NSLICE - 1);
    assign slice_sum = {1'b0, op_a[cnt]} + {1'b0, op_b[cnt]} + {{CHUNK{1'b0}}, carry};

    always_comb begin
        res_next      = res;
        res_next[cnt] = slice_sum[CHUNK-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = in_valid ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

`ifdef ADD_CARRY_SEQ_FLAGS_EN
    // carry into the MSB recovered from the MSB's own sum bit
    logic c_msb;
    assign c_msb = op_a[NSLICE-1][CHUNK-1] ^ op_b[NSLICE-1][CHUNK-1] ^ slice_sum[CHUNK-1];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
`ifdef ADD_CARRY_SEQ_FLAGS_EN
            ovf   <= 1'b0;
            zero  <= 1'b0;
`endif
        end else begin
            if (state == IDLE && in_valid) begin
                op_a  <= a;
                op_b  <= sub ? ~b : b;
                carry <= sub | cin;
                cnt   <= '0;
            end
            if (state == RUN) begin
                res   <= res_next;
                carry <= slice_sum[CHUNK];
                cnt   <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    cout <= slice_sum[CHUNK];
`ifdef ADD_CARRY_SEQ_FLAGS_EN
                    ovf  <= c_msb ^ slice_sum[CHUNK];
                    zero <= res_next == '0;
`endif
                end
            end
        end
    end
endmodule
